// File: rtl/ps2_key_events.sv
// ps2_key_events: turns a stream of PS/2 set-2 scan-code bytes into game
// events for Flappy Bird. It tracks make/break/extended prefixes, keeps held
// state for space, P and Enter, and produces a rate-limited flap pulse, a
// pause level, a restart pulse and a sticky keyboard-error flag.
module ps2_key_events #(
  parameter int unsigned COOLDOWN_CYC   = 2_500_000,
  parameter int unsigned PREFIX_TMO_CYC = 100_000,
  parameter logic [7:0]  KEY_SPACE      = 8'h29,
  parameter logic [7:0]  KEY_P          = 8'h4D,
  parameter logic [7:0]  KEY_ENTER      = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       flap,
  output logic       paused,
  output logic       restart,
  output logic       space_held,
  output logic       kbd_error
);

  // Counter widths; guard against a zero parameter collapsing a width to 0.
  localparam int CD_W  = (COOLDOWN_CYC   > 0) ? $clog2(COOLDOWN_CYC + 1)   : 1;
  localparam int TMO_W = (PREFIX_TMO_CYC > 0) ? $clog2(PREFIX_TMO_CYC + 1) : 1;

  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_CYC);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(PREFIX_TMO_CYC);

  // Protocol bytes with special meaning when seen outside a prefix.
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_ECHO   = 8'hEE;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ERR0   = 8'h00;
  localparam logic [7:0] BYTE_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PFX_E0   = 2'd1,
    PFX_F0   = 2'd2,
    PFX_E0F0 = 2'd3
  } state_t;

  state_t            state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [CD_W-1:0]   cd_cnt;
  logic              p_held;
  logic              enter_held;

  // Byte classification for the current rx_valid cycle.
  logic is_err;
  logic is_status;
  logic norm_make;
  logic norm_break;
  logic mk_space;
  logic mk_p;
  logic mk_enter;
  logic brk_space;
  logic brk_p;
  logic brk_enter;

  // Cooldown counts down to zero and stays there.
  function automatic logic [CD_W-1:0] cd_step(input logic [CD_W-1:0] c);
    return (c == '0) ? c : c - CD_W'(1);
  endfunction

  // Classify the incoming byte as a plain make or plain break of a game key;
  // extended sequences never produce either.
  always_comb begin
    is_err     = (rx_data == BYTE_ERR0) || (rx_data == BYTE_ERR1);
    is_status  = (rx_data == BYTE_BAT_OK) || (rx_data == BYTE_ACK) ||
                 (rx_data == BYTE_ECHO)   || (rx_data == BYTE_RESEND);
    norm_make  = rx_valid && (state == IDLE) &&
                 (rx_data != BYTE_E0) && (rx_data != BYTE_F0) &&
                 !is_err && !is_status;
    norm_break = rx_valid && (state == PFX_F0);
    mk_space   = norm_make  && (rx_data == KEY_SPACE);
    mk_p       = norm_make  && (rx_data == KEY_P);
    mk_enter   = norm_make  && (rx_data == KEY_ENTER);
    brk_space  = norm_break && (rx_data == KEY_SPACE);
    brk_p      = norm_break && (rx_data == KEY_P);
    brk_enter  = norm_break && (rx_data == KEY_ENTER);
  end

  // Parser state, prefix timeout, cooldown, held keys and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      cd_cnt     <= '0;
      p_held     <= 1'b0;
      enter_held <= 1'b0;
      flap       <= 1'b0;
      paused     <= 1'b0;
      restart    <= 1'b0;
      space_held <= 1'b0;
      kbd_error  <= 1'b0;
    end else begin
      flap    <= 1'b0;
      restart <= 1'b0;
      cd_cnt  <= cd_step(cd_cnt);

      // A byte arriving on the expiry cycle still belongs to the prefix;
      // only an empty expiry cycle abandons it.
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == BYTE_E0) begin
              state   <= PFX_E0;
              tmo_cnt <= TMO_LOAD;
            end else if (rx_data == BYTE_F0) begin
              state   <= PFX_F0;
              tmo_cnt <= TMO_LOAD;
            end else if (is_err) begin
              kbd_error <= 1'b1;
            end
          end
        end
        PFX_E0: begin
          if (rx_valid) begin
            if (rx_data == BYTE_F0) begin
              state   <= PFX_E0F0;
              tmo_cnt <= TMO_LOAD;
            end else begin
              state <= IDLE;
            end
          end else if (tmo_cnt == '0) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        PFX_F0, PFX_E0F0: begin
          if (rx_valid) begin
            state <= IDLE;
          end else if (tmo_cnt == '0) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Spacebar: only the first make of a press can flap; repeats while
      // held and presses during pause or cooldown are dropped, not queued.
      if (mk_space && !space_held) begin
        space_held <= 1'b1;
        if (!paused && (cd_cnt == '0)) begin
          flap   <= 1'b1;
          cd_cnt <= CD_LOAD;
        end
      end
      if (brk_space) begin
        space_held <= 1'b0;
      end

      // P toggles pause once per physical press.
      if (mk_p && !p_held) begin
        paused <= !paused;
        p_held <= 1'b1;
      end
      if (brk_p) begin
        p_held <= 1'b0;
      end

      // Enter restarts and always leaves the game unpaused.
      if (mk_enter && !enter_held) begin
        restart    <= 1'b1;
        paused     <= 1'b0;
        enter_held <= 1'b1;
      end
      if (brk_enter) begin
        enter_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_events.sv
// Testbench for ps2_key_events: directed scenarios followed by random byte
// traffic, all compared every cycle against a deadline-based event model.
module tb_ps2_key_events;

  localparam int CD  = 20;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       flap;
  logic       paused;
  logic       restart;
  logic       space_held;
  logic       kbd_error;

  ps2_key_events #(
    .COOLDOWN_CYC  (CD),
    .PREFIX_TMO_CYC(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .flap      (flap),
    .paused    (paused),
    .restart   (restart),
    .space_held(space_held),
    .kbd_error (kbd_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int flap_cnt = 0;
  int restart_cnt = 0;
  int fc0 = 0;
  int rc0 = 0;

  // Reference model: prefix kind plus the cycle it was entered, and the
  // cycle of the last flap; timeouts and cooldown are deadline comparisons.
  int m_pfx = 0;        // 0 none, 1 E0, 2 F0, 3 E0 F0
  int m_pfx_cyc = 0;
  int m_last_flap = 0;
  bit m_armed = 0;
  bit m_space = 0;
  bit m_p = 0;
  bit m_enter = 0;
  bit m_paused = 0;
  bit m_err = 0;
  bit e_flap = 0;
  bit e_restart = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_make(input logic [7:0] d, input int c);
    if (d == 8'h29) begin
      if (!m_space) begin
        m_space = 1;
        if (!m_paused && (!m_armed || c >= m_last_flap + 1 + CD)) begin
          e_flap = 1;
          m_armed = 1;
          m_last_flap = c;
        end
      end
    end else if (d == 8'h4D) begin
      if (!m_p) begin
        m_paused = !m_paused;
        m_p = 1;
      end
    end else if (d == 8'h5A) begin
      if (!m_enter) begin
        e_restart = 1;
        m_paused = 0;
        m_enter = 1;
      end
    end
  endtask

  task automatic model_break(input logic [7:0] d);
    if (d == 8'h29) m_space = 0;
    else if (d == 8'h4D) m_p = 0;
    else if (d == 8'h5A) m_enter = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rst, input int c);
    e_flap = 0;
    e_restart = 0;
    if (rst) begin
      m_pfx = 0; m_armed = 0; m_space = 0; m_p = 0; m_enter = 0;
      m_paused = 0; m_err = 0;
    end else begin
      // A prefix is live up to and including cycle entry+1+TMO.
      if (m_pfx != 0 && c > m_pfx_cyc + 1 + TMO) m_pfx = 0;
      if (v) begin
        case (m_pfx)
          0: begin
            if (d == 8'hE0) begin
              m_pfx = 1; m_pfx_cyc = c;
            end else if (d == 8'hF0) begin
              m_pfx = 2; m_pfx_cyc = c;
            end else if (d == 8'h00 || d == 8'hFF) begin
              m_err = 1;
            end else if (!(d == 8'hAA || d == 8'hFA || d == 8'hEE || d == 8'hFE)) begin
              model_make(d, c);
            end
          end
          1: begin
            if (d == 8'hF0) begin
              m_pfx = 3; m_pfx_cyc = c;
            end else begin
              m_pfx = 0;
            end
          end
          2: begin
            model_break(d);
            m_pfx = 0;
          end
          default: m_pfx = 0;
        endcase
      end
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit rst);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    reset    = rst;
    @(posedge clk);
    cyc++;
    model_step(v, d, rst, cyc);
    #1;
    if (flap === 1'b1) flap_cnt++;
    if (restart === 1'b1) restart_cnt++;
    chk("flap", {7'd0, flap}, {7'd0, e_flap});
    chk("restart", {7'd0, restart}, {7'd0, e_restart});
    chk("space_held", {7'd0, space_held}, {7'd0, m_space});
    chk("paused", {7'd0, paused}, {7'd0, m_paused});
    chk("kbd_error", {7'd0, kbd_error}, {7'd0, m_err});
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int gap;
    logic [7:0] b;

    // Reset state
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    chk("rst_flap", {7'd0, flap}, 8'd0);
    chk("rst_paused", {7'd0, paused}, 8'd0);
    chk("rst_restart", {7'd0, restart}, 8'd0);
    chk("rst_space", {7'd0, space_held}, 8'd0);
    chk("rst_err", {7'd0, kbd_error}, 8'd0);
    idle(3);

    // Repeat suppression
    fc0 = flap_cnt;
    send(8'h29); chk("rep_flap1", {7'd0, flap}, 8'd1); chk("rep_sh1", {7'd0, space_held}, 8'd1);
    idle(1);     chk("rep_width", {7'd0, flap}, 8'd0);
    idle(28);
    send(8'h29); chk("rep_sh2", {7'd0, space_held}, 8'd1); idle(29);
    send(8'h29); chk("rep_sh3", {7'd0, space_held}, 8'd1); idle(29);
    send(8'hF0); send(8'h29); chk("rep_sh4", {7'd0, space_held}, 8'd0); idle(29);
    send(8'h29); chk("rep_flap2", {7'd0, flap}, 8'd1); chk("rep_sh5", {7'd0, space_held}, 8'd1);
    idle(2);
    chk("rep_count", flap_cnt[7:0] - fc0[7:0], 8'd2);

    // Cooldown: make at t+10 dropped
    send(8'hF0); send(8'h29); idle(30);
    send(8'h29); send(8'hF0); send(8'h29); idle(7);
    send(8'h29); chk("cd_10_drop", {7'd0, flap}, 8'd0);
    // make at t+20 dropped (last blocked cycle)
    send(8'hF0); send(8'h29); idle(30);
    send(8'h29); send(8'hF0); send(8'h29); idle(17);
    send(8'h29); chk("cd_20_drop", {7'd0, flap}, 8'd0);
    // make at t+21 accepted
    send(8'hF0); send(8'h29); idle(30);
    send(8'h29); send(8'hF0); send(8'h29); idle(18);
    send(8'h29); chk("cd_21_flap", {7'd0, flap}, 8'd1);

    // Pause and restart
    send(8'hF0); send(8'h29); idle(30);
    send(8'h4D); chk("pause_on", {7'd0, paused}, 8'd1);
    send(8'hF0); send(8'h4D);
    send(8'h29); chk("pause_noflap", {7'd0, flap}, 8'd0); chk("pause_hold", {7'd0, paused}, 8'd1);
    send(8'h5A); chk("restart_pulse", {7'd0, restart}, 8'd1); chk("restart_unpause", {7'd0, paused}, 8'd0);
    idle(1);     chk("restart_width", {7'd0, restart}, 8'd0);
    send(8'hF0); send(8'h29);
    send(8'h29); chk("resume_flap", {7'd0, flap}, 8'd1);
    send(8'hF0); send(8'h5A);

    // Extended codes
    send(8'hF0); send(8'h29); idle(25);
    fc0 = flap_cnt; rc0 = restart_cnt;
    send(8'hE0); send(8'h29);
    send(8'hE0); send(8'hF0); send(8'h29);
    send(8'hE0); send(8'h5A);
    idle(2);
    chk("ext_noflap", flap_cnt[7:0] - fc0[7:0], 8'd0);
    chk("ext_norestart", restart_cnt[7:0] - rc0[7:0], 8'd0);
    chk("ext_space", {7'd0, space_held}, 8'd0);

    // Prefix timeout: 9-cycle wait expires, 8 is still in time, 7 too
    idle(25);
    send(8'hF0); idle(9);
    send(8'h29); chk("tmo9_flap", {7'd0, flap}, 8'd1); chk("tmo9_sh", {7'd0, space_held}, 8'd1);
    send(8'hF0); idle(8);
    send(8'h29); chk("tmo8_sh", {7'd0, space_held}, 8'd0);
    idle(25);
    send(8'h29); send(8'hF0); send(8'h29); idle(25);
    send(8'hF0); idle(7);
    send(8'h29); chk("tmo7_noflap", {7'd0, flap}, 8'd0); chk("tmo7_sh", {7'd0, space_held}, 8'd0);

    // Errors and reset
    send(8'hFF); chk("err_set", {7'd0, kbd_error}, 8'd1);
    send(8'hAA); send(8'h4D); send(8'hF0); send(8'h4D); send(8'h29);
    chk("err_sticky", {7'd0, kbd_error}, 8'd1);
    send(8'hF0);
    tick(1'b1, 8'h29, 1'b1);
    chk("rstm_flap", {7'd0, flap}, 8'd0);
    chk("rstm_paused", {7'd0, paused}, 8'd0);
    chk("rstm_restart", {7'd0, restart}, 8'd0);
    chk("rstm_space", {7'd0, space_held}, 8'd0);
    chk("rstm_err", {7'd0, kbd_error}, 8'd0);
    send(8'h29); chk("post_rst_flap", {7'd0, flap}, 8'd1); chk("post_rst_sh", {7'd0, space_held}, 8'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3: b = 8'h29;
        4, 5:       b = 8'h4D;
        6:          b = 8'h5A;
        7, 8, 9:    b = 8'hF0;
        10:         b = 8'hE0;
        11:         b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFE;
        12:         b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'hEE;
        default:    b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        tick(1'($urandom_range(0, 1)), b, 1'b1);
      end else begin
        send(b);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: gap = 0;
        4, 5:       gap = $urandom_range(1, 4);
        6, 7:       gap = $urandom_range(6, 11);
        default:    gap = $urandom_range(15, 25);
      endcase
      idle(gap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
